fp_unit_arb: RTL and testbench
==============================

FP_UNIT_ARB -- requirements
Module: fp_unit_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one FP unit.
REQ-002 SHALL have parameter LATENCY, default 5, cycles from operands on oUnitA/oUnitB to result on iUnitResult (range 1..16).
REQ-003 iCLK  input  1  sole clock; all state updates on posedge.
REQ-004 iRST  input  1  reset, asynchronous, active-high.
REQ-005 iReq  input  NREQ  per-requester request; held until granted.
REQ-006 iOpA  input  32*NREQ  operand A, requester i in bits [32i+31:32i].
REQ-007 iOpB  input  32*NREQ  operand B, same packing.
REQ-008 iHold  input  1  when 1, no new grant issued.
REQ-009 oGnt  output  NREQ  one-hot grant, combinational, same cycle as accepted request.
REQ-010 oUnitA  output  32  registered operand A to shared unit.
REQ-011 oUnitB  output  32  registered operand B to shared unit.
REQ-012 oUnitValid  output  1  registered; oUnitA/oUnitB carry an issued operation.
REQ-013 iUnitResult  input  32  result from shared unit, LATENCY cycles after issue.
REQ-014 oResult  output  32  registered result, shared by all requesters.
REQ-015 oResultValid  output  NREQ  registered one-hot; bit i marks oResult as requester i's.

Function
REQ-016 Acceptance: request i accepted in cycle t iff iReq[i] and oGnt[i] in t; at most one oGnt bit high per cycle.
REQ-017 oGnt SHALL be all-zero when iHold=1 or iReq=0.
REQ-018 Round-robin: pointer P; winner is first set iReq bit scanning P, P+1, ... NREQ-1, 0, ... P-1 (wrap-around).
REQ-019 After acceptance of i, P SHALL become (i+1) mod NREQ; P unchanged when nothing is accepted.
REQ-020 Issue: on acceptance in t, oUnitA/oUnitB SHALL hold that requester's iOpA/iOpB slice and oUnitValid=1 in t+1; otherwise oUnitValid=0 in t+1 and oUnitA/oUnitB hold previous values.
REQ-021 Tag pipeline: LATENCY-deep shift register of {valid, requester index} advanced every cycle, entry inserted at issue; no stall path.
REQ-022 Return: operation issued (oUnitValid=1) in cycle u SHALL produce oResult=iUnitResult sampled in u+LATENCY, with oResultValid[index]=1 in u+LATENCY+1.
REQ-023 Total latency accept-to-oResultValid: LATENCY+2 cycles; one accept per cycle sustained; throughput 1/cycle.
REQ-024 oResultValid SHALL be 0 in cycles with no retiring tag; oResult then holds last value.
REQ-025 Requester deasserting iReq before grant: no operation issued, no result returned.
REQ-026 iHold asserted mid-stream: in-flight tags continue retiring unaffected.

Reset
REQ-027 iRST=1 SHALL immediately clear: P=0, oUnitA=0, oUnitB=0, oUnitValid=0, oResult=0, oResultValid=0, all tag valids=0.
REQ-028 Reset mid-operation SHALL discard in-flight operations; no oResultValid for them after reset release.
REQ-029 First grant possible in the first rising edge cycle after iRST deasserts.

Configuration
REQ-030 Macro FP_UNIT_ARB_PRIO0_EN: when defined, requester 0 wins whenever iReq[0]=1, remaining requesters round-robin as REQ-018/019 (P never points at 0 unless only 0 requests); when undefined, pure round-robin over all NREQ.

Verification
REQ-031 Reset then iReq=4'b1111 held, iHold=0 -> oGnt sequence 0001,0010,0100,1000,0001 (macro off).
REQ-032 Single iReq[2], iOpA=32'h40000000, iOpB=32'h40400000, unit model = FP multiply with LATENCY=5 -> oResult=32'h40C00000, oResultValid=4'b0100 exactly 7 cycles after accept.
REQ-033 iReq=4'b1001 with P=1 -> grant 1000 then 0001; with macro on -> 0001 every cycle while iReq[0]=1.
REQ-034 Back-to-back accepts from requesters 1,3,1 -> oResultValid 0010,1000,0010 on consecutive cycles, results in issue order.
REQ-035 iHold=1 for 3 cycles with iReq=4'b0011 -> oGnt=0 and oUnitValid=0 during hold, earlier in-flight results still retire.
REQ-036 Assert iRST two cycles after an accept -> all outputs zero immediately; no oResultValid for that operation after release.

Source files
------------

// File: rtl/fp_unit_arb.sv
// rtl/fp_unit_arb.sv - round-robin arbiter sharing one pipelined FP unit among NREQ requesters
// Optional FP_UNIT_ARB_PRIO0_EN: requester 0 has fixed priority over the round-robin group.
module fp_unit_arb #(
   parameter int NREQ    = 4,
   parameter int LATENCY = 5
) (
   input  logic                 iCLK,
   input  logic                 iRST,
   input  logic [NREQ-1:0]      iReq,
   input  logic [32*NREQ-1:0]   iOpA,
   input  logic [32*NREQ-1:0]   iOpB,
   input  logic                 iHold,
   output logic [NREQ-1:0]      oGnt,
   output logic [31:0]          oUnitA,
   output logic [31:0]          oUnitB,
   output logic                 oUnitValid,
   input  logic [31:0]          iUnitResult,
   output logic [31:0]          oResult,
   output logic [NREQ-1:0]      oResultValid
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef FP_UNIT_ARB_PRIO0_EN
   // Pointer skips requester 0, which never needs a round-robin turn.
   localparam logic [IW-1:0] WRAP_PTR = IW'((NREQ > 1) ? 1 : 0);
`else
   localparam logic [IW-1:0] WRAP_PTR = '0;
`endif

   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   win_idx;
   logic            win_vld;
   logic [31:0]     sel_a, sel_b;
   logic [31:0]     unit_a_q, unit_b_q, result_q;
   logic            unit_vld_q;
   logic [IW-1:0]   issue_idx_q;
   logic [NREQ-1:0] rvalid_q, ret_onehot;
   logic            tag_v_q   [1:LATENCY];
   logic [IW-1:0]   tag_idx_q [1:LATENCY];

   always_comb begin
      int j;
      j       = 0;
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr_q) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!win_vld && iReq[IW'(j)]) begin
            win_vld = 1'b1;
            win_idx = IW'(j);
         end
      end
`ifdef FP_UNIT_ARB_PRIO0_EN
      if (iReq[0]) begin
         win_vld = 1'b1;
         win_idx = '0;
      end
`endif
      if (iHold || iRST) win_vld = 1'b0;
   end

   always_comb begin
      oGnt  = '0;
      sel_a = '0;
      sel_b = '0;
      ptr_d = ptr_q;
      if (win_vld) oGnt[win_idx] = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == IW'(i)) begin
            sel_a = iOpA[32*i +: 32];
            sel_b = iOpB[32*i +: 32];
         end
      end
      if (win_vld) begin
         if (int'(win_idx) == NREQ - 1) ptr_d = WRAP_PTR;
         else                           ptr_d = win_idx + IW'(1);
`ifdef FP_UNIT_ARB_PRIO0_EN
         if (win_idx == '0) ptr_d = ptr_q;
`endif
      end
   end

   always_comb begin
      ret_onehot = '0;
      ret_onehot[tag_idx_q[LATENCY]] = 1'b1;
   end

   // Tag stage 1 is fed from the issue register so tags line up with oUnitValid.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         ptr_q       <= '0;
         unit_a_q    <= '0;
         unit_b_q    <= '0;
         unit_vld_q  <= 1'b0;
         issue_idx_q <= '0;
         result_q    <= '0;
         rvalid_q    <= '0;
         for (int k = 1; k <= LATENCY; k++) begin
            tag_v_q[k]   <= 1'b0;
            tag_idx_q[k] <= '0;
         end
      end else begin
         ptr_q      <= ptr_d;
         unit_vld_q <= win_vld;
         if (win_vld) begin
            unit_a_q    <= sel_a;
            unit_b_q    <= sel_b;
            issue_idx_q <= win_idx;
         end
         tag_v_q[1]   <= unit_vld_q;
         tag_idx_q[1] <= issue_idx_q;
         for (int k = 2; k <= LATENCY; k++) begin
            tag_v_q[k]   <= tag_v_q[k-1];
            tag_idx_q[k] <= tag_idx_q[k-1];
         end
         if (tag_v_q[LATENCY]) begin
            result_q <= iUnitResult;
            rvalid_q <= ret_onehot;
         end else begin
            rvalid_q <= '0;
         end
      end
   end

   assign oUnitA       = unit_a_q;
   assign oUnitB       = unit_b_q;
   assign oUnitValid   = unit_vld_q;
   assign oResult      = result_q;
   assign oResultValid = rvalid_q;

endmodule

// File: tb/tb_fp_unit_arb.sv
// tb/tb_fp_unit_arb.sv - self-checking bench for fp_unit_arb with an FP-multiply unit model
module tb_fp_unit_arb;
   localparam int NREQ = 4;
   localparam int LAT  = 5;

   logic                iCLK = 1'b0;
   logic                iRST;
   logic [NREQ-1:0]     iReq;
   logic [32*NREQ-1:0]  iOpA, iOpB;
   logic                iHold;
   logic [NREQ-1:0]     oGnt;
   logic [31:0]         oUnitA, oUnitB;
   logic                oUnitValid;
   logic [31:0]         iUnitResult;
   logic [31:0]         oResult;
   logic [NREQ-1:0]     oResultValid;

   logic [31:0] opa [NREQ];
   logic [31:0] opb [NREQ];
   logic [31:0] upipe [LAT];

   int errors = 0;
   int checks = 0;

   fp_unit_arb #(.NREQ(NREQ), .LATENCY(LAT)) dut (
      .iCLK(iCLK), .iRST(iRST), .iReq(iReq), .iOpA(iOpA), .iOpB(iOpB), .iHold(iHold),
      .oGnt(oGnt), .oUnitA(oUnitA), .oUnitB(oUnitB), .oUnitValid(oUnitValid),
      .iUnitResult(iUnitResult), .oResult(oResult), .oResultValid(oResultValid)
   );

   always #5 iCLK = ~iCLK;

   for (genvar g = 0; g < NREQ; g++) begin : g_pack
      assign iOpA[32*g +: 32] = opa[g];
      assign iOpB[32*g +: 32] = opb[g];
   end

   // Truncating single-precision multiply, normal operands only.
   function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
      logic [47:0] p;
      logic [9:0]  e;
      logic [22:0] m;
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
      if (p[47]) begin
         m = p[46:24];
         e = e + 10'd1;
      end else begin
         m = p[45:23];
      end
      return {a[31] ^ b[31], e[7:0], m};
   endfunction

   always @(posedge iCLK) begin
      for (int k = LAT - 1; k > 0; k--) upipe[k] <= upipe[k-1];
      upipe[0] <= oUnitValid ? fmul(oUnitA, oUnitB) : 32'hDEADBEEF;
   end
   assign iUnitResult = upipe[LAT-1];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      int          cyc;
      int          idx;
      logic [31:0] res;
   } ret_t;

   ret_t        rq[$];
   int          cyc = 0;
   int          mptr;
   bit          exp_uv;
   logic [31:0] exp_a, exp_b, last_res;

   always @(negedge iCLK) begin
      cyc++;
      if (iRST) begin
         chk("rst_gnt", oGnt, 0);
         chk("rst_uvalid", oUnitValid, 0);
         chk("rst_unit_a", oUnitA, 0);
         chk("rst_unit_b", oUnitB, 0);
         chk("rst_result", oResult, 0);
         chk("rst_rvalid", oResultValid, 0);
         mptr = 0; exp_uv = 0; exp_a = 0; exp_b = 0; last_res = 0;
         rq.delete();
      end else begin : model
         int w;
         logic [NREQ-1:0] eg, erv;
         w = -1;
         if (!iHold) begin
            for (int k = 0; k < NREQ; k++)
               if (w < 0 && iReq[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
`ifdef FP_UNIT_ARB_PRIO0_EN
            if (iReq[0]) w = 0;
`endif
         end
         eg = '0;
         if (w >= 0) eg[w] = 1'b1;
         chk("gnt", oGnt, eg);
         chk("uvalid", oUnitValid, exp_uv);
         chk("unit_a", oUnitA, exp_a);
         chk("unit_b", oUnitB, exp_b);
         erv = '0;
         if (rq.size() > 0 && rq[0].cyc == cyc) begin
            erv[rq[0].idx] = 1'b1;
            last_res = rq[0].res;
            void'(rq.pop_front());
         end
         chk("rvalid", oResultValid, erv);
         chk("result", oResult, last_res);
         if (w >= 0) begin
            exp_uv = 1;
            exp_a  = iOpA[32*w +: 32];
            exp_b  = iOpB[32*w +: 32];
            rq.push_back('{cyc + LAT + 2, w, fmul(exp_a, exp_b)});
`ifdef FP_UNIT_ARB_PRIO0_EN
            if (w != 0) mptr = ((w + 1) % NREQ == 0) ? 1 : w + 1;
`else
            mptr = (w + 1) % NREQ;
`endif
         end else begin
            exp_uv = 0;
         end
      end
   end

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic at_neg();
      @(negedge iCLK);
   endtask

   initial begin
      logic [3:0] rr_seq [5];
      int seen;
      rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      iRST = 1'b1; iReq = '0; iHold = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         opa[i] = 32'h3F800000 + (32'(i) << 20);
         opb[i] = 32'h40000000;
      end
      repeat (3) tick();
      iRST = 1'b0;

      iReq = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         at_neg();
         chk($sformatf("rr_gnt%0d", c), oGnt, rr_seq[c]);
         tick();
      end
      iReq = '0;
      repeat (10) tick();

      iReq = 4'b1001;
`ifdef FP_UNIT_ARB_PRIO0_EN
      at_neg(); chk("p1_gnt_a", oGnt, 4'b0001); tick();
      at_neg(); chk("p1_gnt_b", oGnt, 4'b0001); tick();
`else
      at_neg(); chk("p1_gnt_a", oGnt, 4'b1000); tick();
      at_neg(); chk("p1_gnt_b", oGnt, 4'b0001); tick();
`endif
      iReq = '0;
      repeat (10) tick();

      opa[2] = 32'h40000000; opb[2] = 32'h40400000;
      iReq = 4'b0100;
      at_neg(); chk("mul_gnt", oGnt, 4'b0100); tick();
      iReq = '0;
      for (int d = 1; d <= 7; d++) begin
         at_neg();
         if (d < 7) chk($sformatf("mul_early%0d", d), oResultValid, 0);
         else begin
            chk("mul_rvalid", oResultValid, 4'b0100);
            chk("mul_result", oResult, 32'h40C00000);
         end
         tick();
      end
      repeat (5) tick();

      opa[1] = 32'h40800000; opb[1] = 32'h40000000;
      opa[3] = 32'h40400000; opb[3] = 32'h40400000;
      iReq = 4'b0010; at_neg(); chk("b2b_gnt1", oGnt, 4'b0010); tick();
      opa[1] = 32'h3F800000; opb[1] = 32'h40A00000;
      iReq = 4'b1000; at_neg(); chk("b2b_gnt3", oGnt, 4'b1000); tick();
      iReq = 4'b0010; at_neg(); chk("b2b_gnt1b", oGnt, 4'b0010); tick();
      iReq = '0;
      repeat (4) tick();
      at_neg(); chk("b2b_rv0", oResultValid, 4'b0010); chk("b2b_res0", oResult, 32'h41000000); tick();
      at_neg(); chk("b2b_rv1", oResultValid, 4'b1000); chk("b2b_res1", oResult, 32'h41100000); tick();
      at_neg(); chk("b2b_rv2", oResultValid, 4'b0010); chk("b2b_res2", oResult, 32'h40A00000); tick();
      repeat (5) tick();

      iReq = 4'b0001; at_neg(); chk("hold_pre_gnt", oGnt, 4'b0001); tick();
      iReq = '0;
      repeat (4) tick();
      iHold = 1'b1; iReq = 4'b0011;
      for (int h = 0; h < 3; h++) begin
         at_neg();
         chk($sformatf("hold_gnt%0d", h), oGnt, 0);
         chk($sformatf("hold_uv%0d", h), oUnitValid, 0);
         if (h == 2) chk("hold_retire", oResultValid, 4'b0001);
         tick();
      end
      iHold = 1'b0; iReq = 4'b0010;
      at_neg(); chk("unhold_gnt", oGnt, 4'b0010); tick();
      iReq = '0;
      repeat (10) tick();

      iReq = 4'b0100; at_neg(); chk("rst_acc_gnt", oGnt, 4'b0100); tick();
      iReq = '0;
      tick();
      iRST = 1'b1;
      #1;
      chk("arst_uv", oUnitValid, 0);
      chk("arst_a", oUnitA, 0);
      chk("arst_res", oResult, 0);
      chk("arst_rv", oResultValid, 0);
      tick(); tick();
      iRST = 1'b0;
      seen = 0;
      repeat (12) begin
         at_neg();
         if (oResultValid != '0) seen++;
         tick();
      end
      chk("post_rst_rv", seen, 0);
      iReq = 4'b1010; at_neg(); chk("post_rst_gnt", oGnt, 4'b0010); tick();
      iReq = '0;
      repeat (12) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
